// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: pipeline-side bundle for the forwarding / load-use hazard unit.
interface fwd_hazard_unit_if #(
    parameter int NB_REG = 5,
    parameter int N_SRC  = 2
);
    logic [NB_REG-1:0]       i_ex_mem_rd;
    logic [NB_REG-1:0]       i_mem_wb_rd;
    logic                    i_ex_mem_wr_en;
    logic                    i_mem_wb_wr_en;
    logic [N_SRC*NB_REG-1:0] i_id_ex_src;
    logic [N_SRC*NB_REG-1:0] i_if_id_src;
    logic [N_SRC-1:0]        i_if_id_src_use;
    logic                    i_id_ex_mem_rd;
    logic [NB_REG-1:0]       i_id_ex_rt;
    logic                    i_flush;
    logic [2*N_SRC-1:0]      o_mux_hz;
    logic                    o_stall;
    logic                    o_pc_wr_en;
    logic                    o_if_id_wr_en;
    logic                    o_id_ex_bubble;
    logic [31:0]             o_fwd_cnt;
    logic [31:0]             o_stall_cnt;

    modport master (
        output i_ex_mem_rd, i_mem_wb_rd, i_ex_mem_wr_en, i_mem_wb_wr_en, i_id_ex_src,
               i_if_id_src, i_if_id_src_use, i_id_ex_mem_rd, i_id_ex_rt, i_flush,
        input  o_mux_hz, o_stall, o_pc_wr_en, o_if_id_wr_en, o_id_ex_bubble, o_fwd_cnt, o_stall_cnt
    );

    modport slave (
        input  i_ex_mem_rd, i_mem_wb_rd, i_ex_mem_wr_en, i_mem_wb_wr_en, i_id_ex_src,
               i_if_id_src, i_if_id_src_use, i_id_ex_mem_rd, i_id_ex_rt, i_flush,
        output o_mux_hz, o_stall, o_pc_wr_en, o_if_id_wr_en, o_id_ex_bubble, o_fwd_cnt, o_stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: N_SRC-slot operand forwarding plus MEM_LAT-cycle load-use stall FSM.
// Optional event counters are enabled by defining FWD_STATS_EN.
module fwd_hazard_unit #(
    parameter int NB_REG  = 5,
    parameter int N_SRC   = 2,
    parameter int MEM_LAT = 1
) (
    input logic               i_clk,
    input logic               i_rst,
    fwd_hazard_unit_if.slave  bus
);
    typedef enum logic {IDLE, STALL} state_t;

    state_t             r_state;
    logic [2:0]         r_cnt;
    logic [2*N_SRC-1:0] w_mux;
    logic [N_SRC-1:0]   w_use_hit;
    logic               w_hz;
    logic               w_stall;

    for (genvar k = 0; k < N_SRC; k++) begin : g_slot
        logic [NB_REG-1:0] w_src;
        assign w_src = bus.i_id_ex_src[k*NB_REG +: NB_REG];
        assign w_mux[2*k +: 2] =
            (bus.i_ex_mem_wr_en && bus.i_ex_mem_rd != '0 && bus.i_ex_mem_rd == w_src) ? 2'b01 :
            (bus.i_mem_wb_wr_en && bus.i_mem_wb_rd != '0 && bus.i_mem_wb_rd == w_src) ? 2'b10 : 2'b00;
        assign w_use_hit[k] = bus.i_if_id_src_use[k] &&
                              bus.i_if_id_src[k*NB_REG +: NB_REG] == bus.i_id_ex_rt;
    end

    assign w_hz    = bus.i_id_ex_mem_rd && bus.i_id_ex_rt != '0 && |w_use_hit;
    // Reset gating keeps the stall low while reset is held even if a hazard is presented.
    assign w_stall = i_rst && !bus.i_flush && (r_state == STALL || w_hz);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (bus.i_flush) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (r_state == IDLE) begin
            if (w_hz && MEM_LAT > 1) begin
                r_state <= STALL;
                r_cnt   <= 3'(MEM_LAT - 1);
            end
        end else begin
            r_cnt <= r_cnt - 3'd1;
            if (r_cnt == 3'd1)
                r_state <= IDLE;
        end
    end

    assign bus.o_mux_hz       = w_mux;
    assign bus.o_stall        = w_stall;
    assign bus.o_pc_wr_en     = !w_stall;
    assign bus.o_if_id_wr_en  = !w_stall;
    assign bus.o_id_ex_bubble = w_stall;

`ifdef FWD_STATS_EN
    logic [31:0] r_fwd_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_fwd_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (|w_mux && r_fwd_cnt != 32'hFFFF_FFFF)
                r_fwd_cnt <= r_fwd_cnt + 32'd1;
            if (w_stall && r_stall_cnt != 32'hFFFF_FFFF)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.o_fwd_cnt   = r_fwd_cnt;
    assign bus.o_stall_cnt = r_stall_cnt;
`else
    assign bus.o_fwd_cnt   = '0;
    assign bus.o_stall_cnt = '0;
`endif
endmodule
